// File: rtl/bsg_axil_fifo_master_arbiter_if.sv
// Request/response bundle between N requesters, the arbiter, and the AXI-Lite FIFO master.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface bsg_axil_fifo_master_arbiter_if #(
  parameter int unsigned num_req_p         = 2,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32
);
  localparam int unsigned mask_width_lp = axil_data_width_p >> 3;

  logic [num_req_p*axil_data_width_p-1:0] req_data_i;
  logic [num_req_p*axil_addr_width_p-1:0] req_addr_i;
  logic [num_req_p*mask_width_lp-1:0]     req_wmask_i;
  logic [num_req_p-1:0]                   req_w_i;
  logic [num_req_p-1:0]                   req_v_i;
  logic [num_req_p-1:0]                   req_ready_and_o;

  logic [axil_data_width_p-1:0]           resp_data_o;
  logic [num_req_p-1:0]                   resp_v_o;
  logic [num_req_p-1:0]                   resp_ready_and_i;

  logic [axil_data_width_p-1:0]           m_data_o;
  logic [axil_addr_width_p-1:0]           m_addr_o;
  logic [mask_width_lp-1:0]               m_wmask_o;
  logic                                   m_w_o;
  logic                                   m_v_o;
  logic                                   m_ready_and_i;

  logic [axil_data_width_p-1:0]           m_data_i;
  logic                                   m_v_i;
  logic                                   m_ready_and_o;

  modport slave (
    input  req_data_i, req_addr_i, req_wmask_i, req_w_i, req_v_i,
    output req_ready_and_o,
    output resp_data_o, resp_v_o,
    input  resp_ready_and_i,
    output m_data_o, m_addr_o, m_wmask_o, m_w_o, m_v_o,
    input  m_ready_and_i,
    input  m_data_i, m_v_i,
    output m_ready_and_o
  );

  modport master (
    output req_data_i, req_addr_i, req_wmask_i, req_w_i, req_v_i,
    input  req_ready_and_o,
    input  resp_data_o, resp_v_o,
    output resp_ready_and_i,
    input  m_data_o, m_addr_o, m_wmask_o, m_w_o, m_v_o,
    output m_ready_and_i,
    output m_data_i, m_v_i,
    input  m_ready_and_o
  );
endinterface

// File: rtl/bsg_axil_fifo_master_arbiter.sv
// Round-robin arbiter in front of a single AXI-Lite FIFO master port. Granted indices are kept
// in an in-order tag FIFO so in-order responses can be steered back to their owners.
module bsg_axil_fifo_master_arbiter #(
  parameter int unsigned num_req_p         = 2,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32,
  parameter int unsigned max_outstanding_p = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_axil_fifo_master_arbiter_if.slave bus
);
  localparam int unsigned mask_width_lp = axil_data_width_p >> 3;
  localparam int unsigned lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned ptr_w_lp      = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned cnt_w_lp      = $clog2(max_outstanding_p + 1);

  logic [lg_req_lp-1:0] rr_q;
  logic                 lock_q;
  logic [lg_req_lp-1:0] lock_idx_q;
  logic [lg_req_lp-1:0] tag_mem_q [max_outstanding_p];
  logic [ptr_w_lp-1:0]  wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0]  count_q;

  logic [lg_req_lp-1:0] scan_grant, grant, tag_head;
  logic                 found;
  int unsigned          idx;
  logic                 tag_full, tag_v, hs, pop, resp_any;

  // First valid requester at or above the round-robin pointer, wrapping.
  always_comb begin
    scan_grant = rr_q;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && bus.req_v_i[idx]) begin
        found      = 1'b1;
        scan_grant = lg_req_lp'(idx);
      end
    end
  end

  assign grant    = lock_q ? lock_idx_q : scan_grant;
  assign tag_full = (count_q == cnt_w_lp'(max_outstanding_p));
  assign tag_v    = (count_q != '0);
  assign tag_head = tag_mem_q[rd_ptr_q];

  // Handshake outputs are forced low asynchronously while reset is held.
  assign bus.m_v_o  = reset_n_i & bus.req_v_i[grant] & ~tag_full;
  assign hs         = bus.m_v_o & bus.m_ready_and_i;
  assign bus.req_ready_and_o = {{(num_req_p-1){1'b0}}, hs} << grant;

  assign bus.m_data_o  = bus.req_data_i[grant*axil_data_width_p +: axil_data_width_p];
  assign bus.m_addr_o  = bus.req_addr_i[grant*axil_addr_width_p +: axil_addr_width_p];
  assign bus.m_wmask_o = bus.req_wmask_i[grant*mask_width_lp +: mask_width_lp];
  assign bus.m_w_o     = bus.req_w_i[grant];

  assign bus.resp_data_o   = bus.m_data_i;
  assign resp_any          = reset_n_i & bus.m_v_i & tag_v;
  assign bus.resp_v_o      = {{(num_req_p-1){1'b0}}, resp_any} << tag_head;
  assign bus.m_ready_and_o = reset_n_i & tag_v & bus.resp_ready_and_i[tag_head];
  assign pop               = bus.m_v_i & bus.m_ready_and_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < max_outstanding_p; i++) tag_mem_q[i] <= '0;
    end else begin
      if (hs) begin
        rr_q                <= (grant == lg_req_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
        lock_q              <= 1'b0;
        tag_mem_q[wr_ptr_q] <= grant;
        wr_ptr_q <= (wr_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      end else if (bus.m_v_o) begin
        // Stalled by the master: freeze the presented request until it is taken.
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (hs && !pop)      count_q <= count_q + 1'b1;
      else if (!hs && pop) count_q <= count_q - 1'b1;
    end
  end

  // A response with no outstanding tag has no owner.
  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(bus.m_v_i && !tag_v));

endmodule

// File: tb/tb_bsg_axil_fifo_master_arbiter.sv
// Bench for the AXI-Lite master arbiter: directed vector table, corner sequences, and random
// traffic checked against a queue-based model of grant order and response ownership.
module tb_bsg_axil_fifo_master_arbiter;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MW  = DW / 8;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_axil_fifo_master_arbiter_if #(
    .num_req_p(N), .axil_data_width_p(DW), .axil_addr_width_p(AW)
  ) bus ();

  bsg_axil_fifo_master_arbiter #(
    .num_req_p(N), .axil_data_width_p(DW), .axil_addr_width_p(AW), .max_outstanding_p(MAX)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
  );

  logic [DW-1:0] data_a [N];
  logic [AW-1:0] addr_a [N];
  logic [MW-1:0] mask_a [N];
  logic [N-1:0]  w_a;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: outstanding owners in issue order, rotating priority, and a held grant on stall.
  int q[$];
  int rr_m = 0;
  bit lock_m = 0;
  int held_m = 0;
  int g_m;
  bit mv_m, mrdy_m;

  typedef struct {
    logic [N-1:0]  rv;
    logic          mr;
    logic [N-1:0]  rrdy;
    logic          e_mv;
    logic [N-1:0]  e_rdy;
    logic [AW-1:0] e_addr;
    logic          e_mrdy;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [N-1:0] rv, input logic mr, input logic [N-1:0] rrdy,
                       input logic mvi, input logic [DW-1:0] md);
    bit found;
    int idx;
    for (int k = 0; k < N; k++) begin
      bus.req_data_i[k*DW +: DW]  = data_a[k];
      bus.req_addr_i[k*AW +: AW]  = addr_a[k];
      bus.req_wmask_i[k*MW +: MW] = mask_a[k];
    end
    bus.req_w_i          = w_a;
    bus.req_v_i          = rv;
    bus.m_ready_and_i    = mr;
    bus.resp_ready_and_i = rrdy;
    bus.m_v_i            = mvi;
    bus.m_data_i         = md;
    #1;
    if (lock_m) g_m = held_m;
    else begin
      g_m   = rr_m;
      found = 0;
      for (int i = 0; i < N; i++) begin
        idx = (rr_m + i) % N;
        if (!found && rv[idx]) begin
          found = 1;
          g_m   = idx;
        end
      end
    end
    mv_m   = rv[g_m] && (q.size() < MAX);
    mrdy_m = (q.size() > 0) ? rrdy[q[0]] : 1'b0;
    chk("m_v", bus.m_v_o, mv_m);
    chk("req_ready", bus.req_ready_and_o, (mv_m && mr) ? (1 << g_m) : 0);
    if (mv_m) begin
      chk("m_addr", bus.m_addr_o, addr_a[g_m]);
      chk("m_data", bus.m_data_o, data_a[g_m]);
      chk("m_wmask", bus.m_wmask_o, mask_a[g_m]);
      chk("m_w", bus.m_w_o, w_a[g_m]);
    end
    chk("m_ready_o", bus.m_ready_and_o, mrdy_m);
    chk("resp_v", bus.resp_v_o, (mvi && q.size() > 0) ? (1 << q[0]) : 0);
    chk("resp_data", bus.resp_data_o, md);
  endtask

  task automatic advance();
    @(posedge clk);
    if (bus.m_v_i && mrdy_m) void'(q.pop_front());
    if (mv_m && bus.m_ready_and_i) begin
      q.push_back(g_m);
      rr_m   = (g_m + 1) % N;
      lock_m = 0;
    end else if (mv_m) begin
      lock_m = 1;
      held_m = g_m;
    end
    @(negedge clk);
  endtask

  // Asserts reset with live inputs, checks outputs drop immediately, releases on a negedge.
  task automatic do_reset();
    bus.req_v_i          = '1;
    bus.m_ready_and_i    = 1'b1;
    bus.resp_ready_and_i = '1;
    bus.m_v_i            = 1'b1;
    reset_n              = 1'b0;
    #1;
    chk("rst_m_v", bus.m_v_o, 0);
    chk("rst_req_ready", bus.req_ready_and_o, 0);
    chk("rst_resp_v", bus.resp_v_o, 0);
    chk("rst_m_ready_o", bus.m_ready_and_o, 0);
    q.delete();
    rr_m   = 0;
    lock_m = 0;
    @(negedge clk);
    @(negedge clk);
    bus.m_v_i = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    addr_a[0] = 32'h10; addr_a[1] = 32'h20;
    data_a[0] = 32'hA0; data_a[1] = 32'hB1;
    mask_a[0] = 4'hF;   mask_a[1] = 4'h3;
    w_a       = 2'b10;

    tbl[0] = '{rv: 2'b11, mr: 1, rrdy: 2'b11, e_mv: 1, e_rdy: 2'b01, e_addr: 32'h10, e_mrdy: 0};
    tbl[1] = '{rv: 2'b11, mr: 1, rrdy: 2'b11, e_mv: 1, e_rdy: 2'b10, e_addr: 32'h20, e_mrdy: 1};
    tbl[2] = '{rv: 2'b11, mr: 0, rrdy: 2'b10, e_mv: 1, e_rdy: 2'b00, e_addr: 32'h10, e_mrdy: 0};
    tbl[3] = '{rv: 2'b11, mr: 1, rrdy: 2'b01, e_mv: 1, e_rdy: 2'b01, e_addr: 32'h10, e_mrdy: 1};
    tbl[4] = '{rv: 2'b01, mr: 1, rrdy: 2'b00, e_mv: 1, e_rdy: 2'b01, e_addr: 32'h10, e_mrdy: 0};
    tbl[5] = '{rv: 2'b11, mr: 1, rrdy: 2'b01, e_mv: 0, e_rdy: 2'b00, e_addr: 32'h20, e_mrdy: 1};
    tbl[6] = '{rv: 2'b10, mr: 0, rrdy: 2'b10, e_mv: 0, e_rdy: 2'b00, e_addr: 32'h20, e_mrdy: 0};

    do_reset();

    // Single read from requester 0 and its response.
    apply(2'b01, 1, 2'b01, 0, 0);
    chk("rd_addr", bus.m_addr_o, 32'h10);
    chk("rd_w", bus.m_w_o, 0);
    advance();
    apply(2'b00, 0, 2'b01, 1, 32'hCAFE_F00D);
    chk("rd_resp_v", bus.resp_v_o, 2'b01);
    chk("rd_resp_data", bus.resp_data_o, 32'hCAFE_F00D);
    advance();
    apply(2'b00, 0, 2'b11, 0, 0);
    chk("rd_count_zero", bus.m_ready_and_o, 0);
    advance();

    // Alternation, stall lock, and fill to capacity from a fresh reset.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].rv, tbl[i].mr, tbl[i].rrdy, 0, 0);
      chk($sformatf("tbl%0d_m_v", i), bus.m_v_o, tbl[i].e_mv);
      chk($sformatf("tbl%0d_req_ready", i), bus.req_ready_and_o, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_m_addr", i), bus.m_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_m_ready_o", i), bus.m_ready_and_o, tbl[i].e_mrdy);
      advance();
    end

    // Full: a pop in the same cycle does not admit the waiting request until the next cycle.
    apply(2'b10, 1, 2'b11, 1, 32'hCAFE_F00D);
    chk("full_pop_m_v", bus.m_v_o, 0);
    chk("full_pop_resp_v", bus.resp_v_o, 2'b01);
    advance();
    apply(2'b10, 1, 2'b11, 0, 0);
    chk("issue_next_cycle", bus.req_ready_and_o, 2'b10);
    advance();

    // Head owned by requester 1 under backpressure, then exactly one pop.
    for (int i = 0; i < 2; i++) begin
      apply(2'b00, 0, 2'b01, 1, 32'h1111);
      chk("bp_resp_v", bus.resp_v_o, 2'b10);
      chk("bp_m_ready_o", bus.m_ready_and_o, 0);
      advance();
    end
    apply(2'b00, 0, 2'b11, 1, 32'h2222);
    chk("bp_release", bus.m_ready_and_o, 1);
    advance();
    apply(2'b00, 0, 2'b11, 1, 32'h3333);
    chk("bp_single_pop", bus.resp_v_o, 2'b01);
    advance();

    // Reset with three tags outstanding, asserted mid-cycle.
    apply(2'b01, 1, 2'b00, 0, 0);
    advance();
    apply(2'b11, 1, 2'b11, 1, 32'h4444);
    #2;
    do_reset();
    apply(2'b11, 1, 2'b11, 0, 0);
    chk("post_rst_grant", bus.req_ready_and_o, 2'b01);
    advance();

    // Requester 1 stalled for three cycles while requester 0 also asks.
    apply(2'b10, 0, 2'b00, 0, 0);
    chk("lock_first", bus.m_addr_o, 32'h20);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(2'b11, 0, 2'b00, 0, 0);
      chk("lock_addr", bus.m_addr_o, 32'h20);
      chk("lock_data", bus.m_data_o, 32'hB1);
      advance();
    end
    apply(2'b11, 1, 2'b00, 0, 0);
    chk("lock_hs", bus.req_ready_and_o, 2'b10);
    advance();
    apply(2'b11, 1, 2'b00, 0, 0);
    chk("lock_next_grant", bus.req_ready_and_o, 2'b01);
    advance();

    // Random traffic against the model.
    for (int t = 0; t < 500; t++) begin
      logic [N-1:0] rv;
      logic         mvi;
      if (!lock_m) begin
        for (int k = 0; k < N; k++) begin
          data_a[k] = $urandom;
          addr_a[k] = $urandom;
          mask_a[k] = MW'($urandom);
        end
        w_a = N'($urandom);
      end
      rv = N'($urandom);
      if (lock_m) rv[held_m] = 1'b1;
      mvi = (q.size() > 0) && ($urandom_range(1, 0) == 1);
      apply(rv, ($urandom_range(3, 0) != 0), N'($urandom), mvi, $urandom);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bsg_axil_fifo_master_arbiter.md
Name: bsg_axil_fifo_master_arbiter

Overview:
- N-requester round-robin arbiter in front of the single request/response port of the AXI-Lite FIFO master.
- Each accepted request records the granted requester index in an in-order tag FIFO. Responses from the master come back in issue order and are steered to the owning requester.
- The tag FIFO depth also caps the number of outstanding transactions.

Parameters:
- num_req_p, 2, number of requesters (>=2).
- axil_data_width_p, 32, data width.
- axil_addr_width_p, 32, address width.
- max_outstanding_p, 4, tag FIFO depth, equal to the maximum number of in-flight transactions (>=1).
- Derived: mask_width_lp = axil_data_width_p>>3; lg_req_lp = `BSG_SAFE_CLOG2(num_req_p).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_data_i  in  num_req_p*axil_data_width_p  per-requester write data, requester k at slice k
- req_addr_i  in  num_req_p*axil_addr_width_p  per-requester address
- req_wmask_i  in  num_req_p*mask_width_lp  per-requester write strobe
- req_w_i  in  num_req_p  1=write, 0=read
- req_v_i  in  num_req_p  request valid
- req_ready_and_o  out  num_req_p  request accepted (valid-ready handshake)
- resp_data_o  out  axil_data_width_p  response data, broadcast to all requesters
- resp_v_o  out  num_req_p  one-hot response valid
- resp_ready_and_i  in  num_req_p  requester can take a response
- m_data_o  out  axil_data_width_p  to master data_i
- m_addr_o  out  axil_addr_width_p  to master addr_i
- m_wmask_o  out  mask_width_lp  to master wmask_i
- m_w_o  out  1  to master w_i
- m_v_o  out  1  to master v_i
- m_ready_and_i  in  1  from master ready_and_o
- m_data_i  in  axil_data_width_p  from master data_o
- m_v_i  in  1  from master v_o
- m_ready_and_o  out  1  to master ready_and_i

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - rr pointer=0, lock=0, tag FIFO empty, outstanding count=0.
  - Outputs while in reset: m_v_o=0, req_ready_and_o=0, resp_v_o=0, m_ready_and_o=0.
  - Deassertion is synchronized by the integrator. The first request can be accepted in the first cycle after reset deasserts.
- Grant selection (combinational):
  - When unlocked, grant is the first k with req_v_i[k]=1, scanning from rr pointer upward with wrap modulo num_req_p.
  - When locked, grant is the held index.
- Issue condition: m_v_o = req_v_i[grant] & ~tag_full.
- Request mux: m_data_o/m_addr_o/m_wmask_o/m_w_o take the slices of the grant index.
- Request handshake: req_ready_and_o[k] = (k==grant) & m_v_o & m_ready_and_i. A handshake occurs when m_v_o & m_ready_and_i.
- Lock:
  - Set when m_v_o=1 and m_ready_and_i=0, holding the current grant.
  - Cleared on the handshake.
  - This guarantees the request presented to the master does not change while it is stalled.
  - While locked, other requesters raising valid do not change the grant.
- rr pointer: on a handshake, becomes (grant+1) mod num_req_p. It is unchanged otherwise, so there is no starvation.
- Tag FIFO:
  - Push the grant index on each request handshake.
  - Pop on each response handshake (m_v_i & m_ready_and_o).
  - tag_full is computed from registered occupancy only. When full, no push occurs even if a pop happens in the same cycle; the issue stalls for one cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - Zero-latency bypass is not required. A request accepted in cycle t can be responded to from cycle t+1.
- Response routing:
  - resp_data_o = m_data_i.
  - resp_v_o[k] = m_v_i & tag_v & (tag_head==k).
  - m_ready_and_o = tag_v & resp_ready_and_i[tag_head].
  - Write acknowledgements (bvalid) are routed identically; resp_data_o is don't-care for writes.
- Error case: m_v_i=1 while the tag FIFO is empty is illegal.
  - Drive m_ready_and_o=0 and resp_v_o=0.
  - A simulation assertion fires.
- Mid-operation reset: all in-flight tags are discarded immediately. The master must be reset with the same reset.

Test Plan:
- Single requester 0 issues read addr 0x10, master returns data 0xCAFE_F00D -> m_addr_o=0x10, m_w_o=0; then resp_v_o=2'b01, resp_data_o=0xCAFE_F00D; count returns to 0.
- Both requesters hold valid continuously with m_ready_and_i=1 -> grants alternate 0,1,0,1; four handshakes in four cycles; tags pushed in order 0,1,0,1.
- Requester 1 presented with m_ready_and_i=0 for 3 cycles while requester 0 raises valid -> m_addr_o/m_data_o stay at requester 1's values; grant stays 1 until the handshake; the next grant is 0.
- max_outstanding_p=4, issue 4 writes with no responses -> 5th request sees m_v_o=0 and req_ready_and_o=0. Return one response -> the 5th request issues in the following cycle, not the same cycle.
- Response for requester 1 at the head with resp_ready_and_i[1]=0 -> m_ready_and_o=0, resp_v_o=2'b10 held, tag not popped; raising resp_ready_and_i[1] pops exactly once.
- Assert reset_n_i low with 3 tags outstanding -> outputs go to reset values asynchronously. After release, count=0, rr pointer=0, first grant goes to requester 0 when both are valid.
